counter_seq_ctrl: RTL and testbench

Run/pause/stop sequencer for the board's 4-bit tick-driven counter. It owns the frequency-division prescaler and the 4-bit counter register. It starts, pauses, resumes and terminates counting on command, in a latched direction, toward a latched limit, at one of four tick rates. It sits between the debounced button/switch front end and the LED/7-segment display path.

---
 rtl/counter_seq_ctrl_pkg.sv | 22 ++
 rtl/counter_seq_ctrl_tick_gen.sv | 38 +++
 rtl/counter_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_counter_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the run/pause/stop counter sequencer: state
// encoding, tick-rate codes and the 1 Hz base divisor.
package counter_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] RATE_1HZ = 2'd0;
    localparam logic [1:0] RATE_2HZ = 2'd1;
    localparam logic [1:0] RATE_4HZ = 2'd2;
    localparam logic [1:0] RATE_8HZ = 2'd3;

    localparam int DIV_1HZ = 100_000_000;

    // One 4-bit step in the latched direction, wrapping modulo 16.
    function automatic logic [3:0] step_value(input logic [3:0] q, input logic up);
        return up ? q + 4'd1 : q - 4'd1;
    endfunction

endpackage

// File: rtl/counter_seq_ctrl_tick_gen.sv
// Frequency-division prescaler: counts 0..Div-1 while Run is high and
// emits a registered one-cycle Tick on the wrap.
module tick_gen #(
    parameter int Bits = 27
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            Run,
    input  logic            Load,
    input  logic [Bits-1:0] Div,
    output logic            Tick
);

    logic [Bits-1:0] r_cnt;
    logic            r_tick;
    logic            w_wrap;

    // >= keeps the counter bounded even if Div ever shrinks mid-count.
    assign w_wrap = (r_cnt >= Div - Bits'(1));

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (Load) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (Run) begin
            r_cnt  <= w_wrap ? '0 : r_cnt + Bits'(1);
            r_tick <= w_wrap;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign Tick = r_tick;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Run/pause/stop sequencer for the 4-bit tick-driven counter: latches the
// direction, rate and limit on Start and steps Q toward the target.
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int BoardFreq = DIV_1HZ,
    parameter int Bits      = 27
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Up,
    input  logic [1:0] RateSel,
    input  logic [3:0] Limit,
    output logic [3:0] Q,
    output logic       Tick,
    output logic       Busy,
    output logic       Done,
    output logic [1:0] o_dbg_state
);

    localparam logic [Bits-1:0] BASE_DIV = Bits'(BoardFreq);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic            r_up;
    logic [1:0]      r_rate;
    logic [3:0]      r_limit;
    logic [3:0]      r_q;
    logic [3:0]      w_next_q;
    logic [3:0]      w_target;
    logic [3:0]      w_stepped;
    logic            r_busy;
    logic            r_done;
    logic            w_fresh_start;
    logic            w_run;
    logic            w_load;
    logic            w_tick;
    logic [Bits-1:0] w_div;

    // Start/Stop are single-cycle pulses; Stop wins when both arrive together.
    assign w_fresh_start = Start && !Stop && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_target      = r_up ? r_limit : 4'd0;
    assign w_stepped     = step_value(r_q, r_up);
    assign w_div         = BASE_DIV >> r_rate;

    always_comb begin
        w_next_state = r_state;
        w_next_q     = r_q;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (Stop) begin
                    w_next_state = ST_IDLE;
                    w_next_q     = 4'd0;
                end else if (Start) begin
                    w_next_q     = Up ? 4'd0 : Limit;
                    w_next_state = (Limit == 4'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // A tick step still lands on a Stop edge; reaching the target beats PAUSE.
                if (w_tick) w_next_q = w_stepped;
                if (w_tick && w_stepped == w_target) w_next_state = ST_DONE;
                else if (Stop)                       w_next_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (Stop) begin
                    w_next_state = ST_IDLE;
                    w_next_q     = 4'd0;
                end else if (Start) begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_q     = 4'd0;
            end
        endcase
    end

    // Resume edge counts as a run edge so a P-cycle pause delays steps by exactly P.
    assign w_run  = (w_next_state == ST_RUN) && !w_fresh_start;
    assign w_load = w_fresh_start || (w_next_state == ST_IDLE) || (w_next_state == ST_DONE);

    tick_gen #(
        .Bits (Bits)
    ) u_tick_gen (
        .Clk  (Clk),
        .Clr  (Clr),
        .Run  (w_run),
        .Load (w_load),
        .Div  (w_div),
        .Tick (w_tick)
    );

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state <= ST_IDLE;
            r_q     <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_up    <= 1'b0;
            r_rate  <= 2'd0;
            r_limit <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_q     <= w_next_q;
            r_busy  <= (w_next_state == ST_RUN) || (w_next_state == ST_PAUSE);
            r_done  <= (w_next_state == ST_DONE);
            if (w_fresh_start) begin
                r_up    <= Up;
                r_rate  <= RateSel;
                r_limit <= Limit;
            end
        end
    end

    assign Q           = r_q;
    assign Tick        = w_tick;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl at BoardFreq = 16 (Div = 16/8/4/2).
module tb_counter_seq_ctrl;
    import counter_seq_ctrl_pkg::*;

    logic       Clk = 1'b0;
    logic       Clr;
    logic       Start;
    logic       Stop;
    logic       Up;
    logic [1:0] RateSel;
    logic [3:0] Limit;
    logic [3:0] Q;
    logic       Tick;
    logic       Busy;
    logic       Done;
    logic [1:0] o_dbg_state;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_v;
    logic [3:0] eq;
    logic       et, eb, ed;

    counter_seq_ctrl #(
        .BoardFreq (16),
        .Bits      (5)
    ) dut (
        .Clk         (Clk),
        .Clr         (Clr),
        .Start       (Start),
        .Stop        (Stop),
        .Up          (Up),
        .RateSel     (RateSel),
        .Limit       (Limit),
        .Q           (Q),
        .Tick        (Tick),
        .Busy        (Busy),
        .Done        (Done),
        .o_dbg_state (o_dbg_state)
    );

    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    // Inputs change at negedge; outputs are read at negedge.
    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic pulse_stop();
        Stop = 1'b1;
        @(negedge Clk);
        Stop = 1'b0;
    endtask

    task automatic test_reset();
        Clr = 1'b1; Start = 1'b0; Stop = 1'b0; Up = 1'b0; RateSel = 2'd0; Limit = 4'd0;
        #2;
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== 9'h000) begin
            n_err++; $display("FAIL reset_values: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, 9'h000);
        end
        @(negedge Clk);
        Clr = 1'b0;
        @(negedge Clk);
        pulse_stop();
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== 9'h000) begin
            n_err++; $display("FAIL idle_stop_ignored: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, 9'h000);
        end
    endtask

    task automatic test_up_count();
        Up = 1'b1; Limit = 4'd5; RateSel = 2'd2;
        pulse_start();
        exp_v = {ST_RUN, 4'd0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
            n_err++; $display("FAIL up_start: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
        end
        for (int c = 1; c <= 24; c++) begin
            @(negedge Clk);
            eq = ((c - 1) / 4 > 5) ? 4'd5 : 4'((c - 1) / 4);
            et = (c % 4 == 0) && (c <= 20);
            eb = (c < 21);
            ed = (c >= 21);
            exp_v = {(ed ? ST_DONE : ST_RUN), eq, et, eb, ed};
            n_cmp++;
            if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
                n_err++; $display("FAIL up_cycle%0d: got %h expected %h", c, {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
            end
        end
    endtask

    task automatic test_down_pause();
        Up = 1'b0; Limit = 4'd9; RateSel = 2'd3;
        pulse_start();
        exp_v = {ST_RUN, 4'd9, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
            n_err++; $display("FAIL down_start: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge Clk);
            exp_v = {ST_RUN, 4'(9 - (c - 1) / 2), (c % 2 == 0), 1'b1, 1'b0};
            n_cmp++;
            if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
                n_err++; $display("FAIL down_cycle%0d: got %h expected %h", c, {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
            end
        end
        pulse_stop();
        // Inputs changed while paused must not be picked up on resume.
        Up = 1'b1; Limit = 4'd3; RateSel = 2'd0;
        for (int i = 0; i <= 10; i++) begin
            exp_v = {ST_PAUSE, 4'd7, 1'b0, 1'b1, 1'b0};
            n_cmp++;
            if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
                n_err++; $display("FAIL pause_hold%0d: got %h expected %h", i, {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
            end
            if (i < 10) @(negedge Clk);
        end
        pulse_start();
        exp_v = {ST_RUN, 4'd7, 1'b1, 1'b1, 1'b0};
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
            n_err++; $display("FAIL resume_tick: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
        end
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            ed = (c >= 13);
            eq = ed ? 4'd0 : 4'(6 - (c - 1) / 2);
            et = (c % 2 == 0) && (c <= 12);
            exp_v = {(ed ? ST_DONE : ST_RUN), eq, et, !ed, ed};
            n_cmp++;
            if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
                n_err++; $display("FAIL resume_cycle%0d: got %h expected %h", c, {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
            end
        end
    endtask

    task automatic test_limit_zero();
        Up = 1'b1; Limit = 4'd0; RateSel = 2'd3;
        pulse_start();
        for (int c = 0; c <= 8; c++) begin
            exp_v = {ST_DONE, 4'd0, 1'b0, 1'b0, 1'b1};
            n_cmp++;
            if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
                n_err++; $display("FAIL limit0_cycle%0d: got %h expected %h", c, {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_stop_on_tick();
        pulse_stop();
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== 9'h000) begin
            n_err++; $display("FAIL done_stop_idle: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, 9'h000);
        end
        Up = 1'b1; Limit = 4'd15; RateSel = 2'd3;
        pulse_start();
        repeat (2) @(negedge Clk);
        pulse_stop();
        for (int i = 0; i < 4; i++) begin
            exp_v = {ST_PAUSE, 4'd1, 1'b0, 1'b1, 1'b0};
            n_cmp++;
            if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
                n_err++; $display("FAIL stop_on_tick%0d: got %h expected %h", i, {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
            end
            @(negedge Clk);
        end
        pulse_stop();
        Limit = 4'd1;
        pulse_start();
        repeat (2) @(negedge Clk);
        pulse_stop();
        exp_v = {ST_DONE, 4'd1, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
            n_err++; $display("FAIL done_beats_pause: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
        end
    endtask

    task automatic test_simultaneous();
        Up = 1'b1; Limit = 4'd15; RateSel = 2'd3;
        pulse_start();
        repeat (3) @(negedge Clk);
        pulse_stop();
        exp_v = {ST_PAUSE, 4'd1, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
            n_err++; $display("FAIL pause_before_both: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
        end
        Start = 1'b1; Stop = 1'b1;
        @(negedge Clk);
        Start = 1'b0; Stop = 1'b0;
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== 9'h000) begin
            n_err++; $display("FAIL start_stop_pause: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, 9'h000);
        end
        pulse_start();
        repeat (7) @(negedge Clk);
        pulse_start();
        for (int c = 8; c <= 11; c++) begin
            eq = 4'((c - 1) / 2);
            exp_v = {ST_RUN, eq, (c % 2 == 0), 1'b1, 1'b0};
            n_cmp++;
            if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
                n_err++; $display("FAIL start_in_run%0d: got %h expected %h", c, {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
            end
            if (c < 11) @(negedge Clk);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_stop();
        pulse_stop();
        Up = 1'b1; Limit = 4'd15; RateSel = 2'd3;
        pulse_start();
        repeat (8) @(negedge Clk);
        exp_v = {ST_RUN, 4'd3, 1'b1, 1'b1, 1'b0};
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
            n_err++; $display("FAIL pre_clr: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
        end
        #1 Clr = 1'b1;
        #1;
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== 9'h000) begin
            n_err++; $display("FAIL async_clr: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, 9'h000);
        end
        #1 Clr = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({o_dbg_state, Q, Tick, Busy, Done} !== 9'h000) begin
            n_err++; $display("FAIL after_clr: got %h expected %h", {o_dbg_state, Q, Tick, Busy, Done}, 9'h000);
        end
    endtask

    task automatic test_latching();
        Up = 1'b1; Limit = 4'd3; RateSel = 2'd2;
        pulse_start();
        Up = 1'b0; Limit = 4'd10; RateSel = 2'd3;
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            ed = (c >= 13);
            eq = ed ? 4'd3 : 4'((c - 1) / 4);
            et = (c % 4 == 0) && (c <= 12);
            exp_v = {(ed ? ST_DONE : ST_RUN), eq, et, !ed, ed};
            n_cmp++;
            if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
                n_err++; $display("FAIL latch_cycle%0d: got %h expected %h", c, {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
            end
        end
        pulse_start();
        for (int c = 0; c <= 3; c++) begin
            eq = (c == 3) ? 4'd9 : 4'd10;
            exp_v = {ST_RUN, eq, (c == 2), 1'b1, 1'b0};
            n_cmp++;
            if ({o_dbg_state, Q, Tick, Busy, Done} !== exp_v) begin
                n_err++; $display("FAIL relatch_cycle%0d: got %h expected %h", c, {o_dbg_state, Q, Tick, Busy, Done}, exp_v);
            end
            if (c < 3) @(negedge Clk);
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_pause();
        test_limit_zero();
        test_stop_on_tick();
        test_simultaneous();
        test_reset_mid_run();
        test_latching();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
